// File: rtl/gpio_defaults_loader_if.sv
// gpio_defaults_loader_if
//   Groups the request/strap inputs and pad-chain outputs of the GPIO
//   defaults loader into one bundle.
//   Signals:
//     defaults     strapped default bits, pad p at [p*CFG_BITS +: CFG_BITS]
//     load_req     level request to (re)load the chain
//     load_ack     one-cycle pulse when a request is accepted
//     busy         high while shifting or latching
//     done         sticky high after a completed load
//     serial_clk   shift clock to the pad chain
//     serial_data  shift data to the pad chain
//     serial_load  one-cycle latch strobe to the pad chain
//   Modports: master (request side / chain observer), slave (the loader).
interface gpio_defaults_loader_if #(
    parameter int unsigned NUM_PADS = 44,
    parameter int unsigned CFG_BITS = 13
);
    localparam int unsigned N = NUM_PADS * CFG_BITS;

    logic [N-1:0] defaults;
    logic         load_req;
    logic         load_ack;
    logic         busy;
    logic         done;
    logic         serial_clk;
    logic         serial_data;
    logic         serial_load;

    modport master (
        output defaults, load_req,
        input  load_ack, busy, done, serial_clk, serial_data, serial_load
    );

    modport slave (
        input  defaults, load_req,
        output load_ack, busy, done, serial_clk, serial_data, serial_load
    );
endinterface

// File: rtl/gpio_defaults_loader.sv
// gpio_defaults_loader
//   Snapshots the strapped per-pad default vector and shifts it MSB first
//   into the daisy-chained GPIO pad control register, using a generated
//   shift clock (two block clocks per bit), then pulses the latch strobe
//   and raises a sticky done flag.
//   Ports:
//     clk    block clock
//     reset  asynchronous, active-high reset
//     bus    gpio_defaults_loader_if.slave (request, strap and chain signals)
//   Parameters: NUM_PADS (pads in chain), CFG_BITS (bits per pad).
//   Build option: GPIO_DEFAULTS_AUTOLOAD_EN -- when defined, the first clk
//   edge after reset release is treated as an accepted load request.
module gpio_defaults_loader #(
    parameter int unsigned NUM_PADS = 44,
    parameter int unsigned CFG_BITS = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    gpio_defaults_loader_if.slave bus
);
    localparam int unsigned N  = NUM_PADS * CFG_BITS;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_snap;
    logic [N-1:0]   w_snap_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_accept;
    logic           w_req;

    logic           r_load_ack;
    logic           r_busy;
    logic           r_done;
    logic           r_serial_clk;
    logic           r_serial_data;
    logic           r_serial_load;

`ifdef GPIO_DEFAULTS_AUTOLOAD_EN
    // High only until the first edge after reset release: acts as a
    // one-shot internal request.
    logic r_first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_first <= 1'b1;
        else       r_first <= 1'b0;
    end

    assign w_req = bus.load_req | r_first;
`else
    assign w_req = bus.load_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT_LO;
                    w_snap_nxt  = bus.defaults;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT_LO: w_state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt = LATCH;
                end else begin
                    // Advance to the next bit on the falling half of serial_clk.
                    w_state_nxt = SHIFT_LO;
                    w_snap_nxt  = r_snap << 1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            LATCH:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe while still having no input-to-output
    // combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_ack    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_serial_clk  <= 1'b0;
            r_serial_data <= 1'b0;
            r_serial_load <= 1'b0;
        end else begin
            r_load_ack    <= w_accept;
            r_busy        <= (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI) ||
                             (w_state_nxt == LATCH);
            r_done        <= (w_state_nxt == DONE);
            r_serial_clk  <= (w_state_nxt == SHIFT_HI);
            r_serial_load <= (w_state_nxt == LATCH);
            r_serial_data <= ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI)) ?
                             w_snap_nxt[N-1] : 1'b0;
        end
    end

    assign bus.load_ack    = r_load_ack;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.serial_clk  = r_serial_clk;
    assign bus.serial_data = r_serial_data;
    assign bus.serial_load = r_serial_load;
endmodule

// File: tb/tb_gpio_defaults_loader.sv
// tb_gpio_defaults_loader
//   Directed-plus-random bench for gpio_defaults_loader. A small instance
//   (2 pads x 3 bits) exercises ordering, snapshot isolation, back-to-back
//   requests and mid-load reset; a default-size instance checks the full
//   572-bit load. The reference model is the loaded vector itself: bits
//   captured at serial_clk rises, packed MSB first, must reproduce it.
module tb_gpio_defaults_loader;
    localparam int NA   = 6;
    localparam int NB   = 572;
    localparam int MAXN = NB;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    gpio_defaults_loader_if #(.NUM_PADS(2), .CFG_BITS(3)) ifa ();
    gpio_defaults_loader_if #(.NUM_PADS(44), .CFG_BITS(13)) ifb ();

    gpio_defaults_loader #(.NUM_PADS(2), .CFG_BITS(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    gpio_defaults_loader #(.NUM_PADS(44), .CFG_BITS(13)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic sel;
    logic s_ack, s_busy, s_done, s_sclk, s_data, s_load;

    always_comb begin
        s_ack  = sel ? ifb.load_ack    : ifa.load_ack;
        s_busy = sel ? ifb.busy        : ifa.busy;
        s_done = sel ? ifb.done        : ifa.done;
        s_sclk = sel ? ifb.serial_clk  : ifa.serial_clk;
        s_data = sel ? ifb.serial_data : ifa.serial_data;
        s_load = sel ? ifb.serial_load : ifa.serial_load;
    end

    task automatic chk(input string tag, input logic [MAXN-1:0] obs, input logic [MAXN-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MAXN-1:0] rand_vec(input int n);
        logic [MAXN-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic set_inputs(input int which, input logic [MAXN-1:0] vec, input logic req);
        if (which == 0) begin
            ifa.defaults = vec[NA-1:0];
            ifa.load_req = req;
        end else begin
            ifb.defaults = vec;
            ifb.load_req = req;
        end
    endtask

    task automatic set_req(input int which, input logic req);
        if (which == 0) ifa.load_req = req;
        else            ifb.load_req = req;
    endtask

    // Called at a negedge; the next posedge must be the accept edge.
    task automatic run_load(input int which, input logic [MAXN-1:0] vec,
                            input bit use_req, input bit flip, input bit hold);
        int n;
        int rises, lat_cyc, lat_cnt, done_cyc, busy_cnt, ack_cnt;
        logic [MAXN-1:0] got;
        logic prev_clk, data_latch;
        n = (which == 0) ? NA : NB;
        sel = (which != 0);
        got = '0; rises = 0; lat_cyc = -1; lat_cnt = 0; done_cyc = -1;
        busy_cnt = 0; ack_cnt = 0; data_latch = 1'bx; prev_clk = 1'b0;
        set_inputs(which, vec, use_req);
        @(posedge clk);
        @(negedge clk);
        chk("ack_c0", s_ack, 1);
        chk("first_bit_c0", s_data, vec[n-1]);
        chk("sclk_c0", s_sclk, 0);
        if (!hold) set_req(which, 1'b0);
        for (int c = 0; c <= 2 * n + 1; c++) begin
            if (c > 0) @(negedge clk);
            if (flip && c == 3) set_inputs(which, ~vec, hold);
            if (s_busy) busy_cnt++;
            if (c > 0 && s_ack) ack_cnt++;
            if (s_sclk && !prev_clk) begin
                rises++;
                got = {got[MAXN-2:0], s_data};
            end
            if (s_load) begin
                lat_cnt++;
                lat_cyc = c;
            end
            if (s_done && done_cyc < 0) done_cyc = c;
            if (c == 2 * n) data_latch = s_data;
            prev_clk = s_sclk;
        end
        chk("shifted_bits", got, vec);
        chk("rise_count", rises, n);
        chk("latch_cycle", lat_cyc, 2 * n);
        chk("latch_count", lat_cnt, 1);
        chk("done_cycle", done_cyc, 2 * n + 1);
        chk("busy_cycles", busy_cnt, 2 * n + 1);
        chk("ack_while_busy", ack_cnt, 0);
        chk("data_in_latch", data_latch, 0);
        if (hold) begin
            @(negedge clk);
            chk("b2b_ack", s_ack, 1);
            chk("b2b_done_cleared", s_done, 0);
            chk("b2b_busy", s_busy, 1);
            set_req(which, 1'b0);
            for (int c = 1; c <= 2 * n + 4 && !s_done; c++) @(negedge clk);
            chk("b2b_reload_done", s_done, 1);
        end
    endtask

    initial begin
        logic [MAXN-1:0] v;
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        reset   = 1'b1;
        ifa.defaults = '0; ifa.load_req = 1'b0;
        ifb.defaults = '0; ifb.load_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ifa.load_ack, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_sclk", ifa.serial_clk, 0);
        chk("rst_sdata", ifa.serial_data, 0);
        chk("rst_sload", ifa.serial_load, 0);
        chk("rst_b_busy", ifb.busy, 0);

`ifdef GPIO_DEFAULTS_AUTOLOAD_EN
        v = rand_vec(NA);
        ifb.defaults = rand_vec(NB);
        ifa.defaults = v[NA-1:0];
        reset = 1'b0;
        run_load(0, v, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2 * NB + 4 && !ifb.done; c++) @(negedge clk);
        chk("auto_b_done", ifb.done, 1);
`else
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_no_ack", ifa.load_ack, 0);
        chk("idle_not_busy", ifa.busy, 0);
        chk("idle_not_done", ifa.done, 0);
`endif

        // Reference pattern 6'b101100: expected shifted sequence 1,0,1,1,0,0.
        v = '0;
        v[NA-1:0] = 6'b101100;
        run_load(0, v, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_sticky", ifa.done, 1);

        // Changing defaults mid-shift must not disturb the snapshot.
        run_load(0, v, 1'b1, 1'b1, 1'b0);

        // Random patterns.
        for (int i = 0; i < 4; i++) begin
            v = rand_vec(NA);
            run_load(0, v, 1'b1, 1'b0, 1'b0);
        end

        // Held request: ignored while busy, re-accepted after done.
        v = rand_vec(NA);
        run_load(0, v, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a load.
        v = rand_vec(NA);
        sel = 1'b0;
        @(negedge clk);
        set_inputs(0, v, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ack", ifa.load_ack, 1);
        ifa.load_req = 1'b0;
        repeat (5) @(posedge clk);
        chk("rst_mid_busy_before", ifa.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_ack0", ifa.load_ack, 0);
        chk("rst_mid_busy0", ifa.busy, 0);
        chk("rst_mid_done0", ifa.done, 0);
        chk("rst_mid_sclk0", ifa.serial_clk, 0);
        chk("rst_mid_sdata0", ifa.serial_data, 0);
        chk("rst_mid_sload0", ifa.serial_load, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef GPIO_DEFAULTS_AUTOLOAD_EN
        for (int c = 0; c < 2 * NB + 4 && !ifb.done; c++) @(negedge clk);
        @(negedge clk);
`endif
        v = rand_vec(NA);
        run_load(0, v, 1'b1, 1'b0, 1'b0);

        // Full-size chain: all ones, then a random pattern.
        v = '1;
        run_load(1, v, 1'b1, 1'b0, 1'b0);
        v = rand_vec(NB);
        run_load(1, v, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
